// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch unit.
// Holds the FSM state, the bus select constant and the buffer entry.
package fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    ABORT = 1'b1
  } fetch_state_e;

  localparam logic [3:0] WB_SEL_ALL = 4'b1111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_if.sv
// Pipelined Wishbone read port used by the prefetch unit.
// Signal names follow the master-side view.
interface fetch_prefetch_if;

  logic        o_wb_cycle;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [29:0] o_wb_addr;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_data;
  logic        i_wb_ack;
  logic        i_wb_stall;
  logic [31:0] i_wb_data;

  modport master (
    output o_wb_cycle, o_wb_stb, o_wb_we,
    output o_wb_addr, o_wb_sel, o_wb_data,
    input  i_wb_ack, i_wb_stall, i_wb_data
  );

  modport slave (
    input  o_wb_cycle, o_wb_stb, o_wb_we,
    input  o_wb_addr, o_wb_sel, o_wb_data,
    output i_wb_ack, i_wb_stall, i_wb_data
  );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular store with a registered head entry.
// Flush empties it synchronously; flush wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  head_q, head_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    rd_d    = rd_q + AW'(do_pop);
    wr_d    = wr_q + AW'(push);
    count_d = count_q + CW'(push) - CW'(do_pop);
    head_d  = '0;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else if (count_d != '0) begin
      // the entry being written becomes the head when it is the only one
      if (push && (wr_q == rd_d)) head_d = din;
      else head_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= din;
  end

  assign dout  = head_q;
  assign count = count_q;

endmodule

// File: rtl/fetch_prefetch.sv
// Credit-throttled instruction prefetcher over pipelined Wishbone.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect yields a trap marker.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_redirect,
  input  logic [31:0]    i_redirect_pc,
  input  logic           i_stall,
  output logic           o_valid,
  output logic [31:0]    o_instruction,
  output logic [31:0]    o_pc,
  output logic           o_misaligned,
  fetch_prefetch_if.master wb
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam logic [CW1-1:0] DEPTH_L = CW1'(DEPTH);
  localparam logic [CW-1:0]  MAX_L   = CW'(MAX_OUTSTANDING);

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  fetch_state_e  state_q, state_d;
  logic [29:0]   fetch_wpc_q, fetch_wpc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic          halt_q, halt_d;
  logic          mark_q, mark_d;

  logic [CW-1:0]  count;
  logic [CW1-1:0] fill;
  fetch_entry_t   head;
  fetch_entry_t   push_entry;
  logic           stb, cyc, accept, ack_ok;
  logic           mark_push, push, pop;
  logic           redir_mis;
  logic [31:0]    redir_pc;

  assign redir_mis = TRAP_EN && (i_redirect_pc[1:0] != 2'b00);
  assign redir_pc  = TRAP_EN ? i_redirect_pc
                             : {i_redirect_pc[31:2], 2'b00};

  always_comb begin
    fill   = {1'b0, outst_q} + {1'b0, count};
    stb    = (state_q == RUN) && !halt_q
          && (outst_q < MAX_L) && (fill < DEPTH_L);
    cyc    = (state_q == RUN) && (stb || (outst_q != '0));
    accept = stb && !wb.i_wb_stall;
    ack_ok = (state_q == RUN) && wb.i_wb_ack
          && (outst_q != '0);
    mark_push = (state_q == RUN) && mark_q;
    push   = !i_redirect && (ack_ok || mark_push);
    pop    = o_valid && !i_stall;
    push_entry.pc         = resp_pc_q;
    push_entry.instr      = mark_push ? 32'h0 : wb.i_wb_data;
    push_entry.misaligned = mark_push;
  end

  always_comb begin
    state_d     = RUN;
    fetch_wpc_d = fetch_wpc_q + 30'(accept);
    resp_pc_d   = ack_ok ? resp_pc_q + 32'd4 : resp_pc_q;
    outst_d     = outst_q + CW'(accept) - CW'(ack_ok);
    halt_d      = halt_q;
    mark_d      = mark_q && !mark_push;
    if (i_redirect) begin
      state_d     = ABORT;
      fetch_wpc_d = redir_pc[31:2];
      resp_pc_d   = redir_pc;
      outst_d     = '0;
      halt_d      = redir_mis;
      mark_d      = redir_mis;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ABORT;
      fetch_wpc_q <= RESET_PC[31:2];
      resp_pc_q   <= RESET_PC;
      outst_q     <= '0;
      halt_q      <= 1'b0;
      mark_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_wpc_q <= fetch_wpc_d;
      resp_pc_q   <= resp_pc_d;
      outst_q     <= outst_d;
      halt_q      <= halt_d;
      mark_q      <= mark_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (i_redirect),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .count (count)
  );

  assign o_valid       = (count != '0);
  assign o_instruction = head.instr;
  assign o_pc          = head.pc;
  assign o_misaligned  = TRAP_EN && head.misaligned;

  assign wb.o_wb_cycle = cyc;
  assign wb.o_wb_stb   = stb;
  assign wb.o_wb_we    = 1'b0;
  assign wb.o_wb_addr  = fetch_wpc_q;
  assign wb.o_wb_sel   = WB_SEL_ALL;
  assign wb.o_wb_data  = 32'h0;

endmodule

// File: doc/fetch_prefetch.md
FETCH_PREFETCH -- requirements
Module: fetch_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, instruction buffer depth; power of two, >= 2.
REQ-002 Parameter MAX_OUTSTANDING, default 2, Wishbone requests in flight; range 1..DEPTH.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 i_redirect  in  1  load new fetch PC and flush (branch/jump/trap).
REQ-007 i_redirect_pc  in  32  new fetch PC.
REQ-008 i_stall  in  1  decode cannot accept this cycle.
REQ-009 o_valid  out  1  buffer head holds an instruction.
REQ-010 o_instruction  out  32  head instruction word.
REQ-011 o_pc  out  32  head instruction address.
REQ-012 o_misaligned  out  1  head entry is a misaligned-fetch marker.
REQ-013 o_wb_cycle, o_wb_stb, o_wb_we  out  1 each  pipelined Wishbone master controls.
REQ-014 o_wb_addr  out  30  word address; o_wb_sel out 4; o_wb_data out 32.
REQ-015 i_wb_ack, i_wb_stall  in  1 each; i_wb_data in 32  Wishbone slave returns.

Function
REQ-016 State machine has two states, RUN and ABORT; ABORT lasts exactly one cycle, then RUN.
REQ-017 o_wb_we=0, o_wb_sel=4'b1111, o_wb_data=0 at all times; o_wb_addr=fetch_pc[31:2].
REQ-018 In RUN, o_wb_stb=1 iff outstanding < MAX_OUTSTANDING and outstanding + count < DEPTH; guarantees buffer never overflows.
REQ-019 o_wb_cycle=1 in RUN while o_wb_stb=1 or outstanding != 0; 0 in ABORT.
REQ-020 Request accepted when o_wb_stb & !i_wb_stall: fetch_pc += 4 (wraps mod 2^32), outstanding += 1.
REQ-021 On i_wb_ack with cycle held: push {resp_pc, i_wb_data, 0}; resp_pc += 4; outstanding -= 1; accept and ack in same cycle leave outstanding unchanged.
REQ-022 Ack-to-o_valid latency exactly one cycle; responses enter the buffer in request order.
REQ-023 o_valid = (count != 0); entry popped when o_valid & !i_stall; push and pop in same cycle keep count unchanged.
REQ-024 i_stall does not stop bus requests; only the credit rule of REQ-018 throttles them.
REQ-025 i_redirect (any state): flush buffer (count=0), outstanding=0, fetch_pc and resp_pc = i_redirect_pc, state=ABORT next cycle; acks received in ABORT ignored.
REQ-026 Redirect and pop in same cycle: redirect wins, popped entry discarded.
REQ-027 Redirect in ABORT: reloads PCs, stays in ABORT one further cycle.
REQ-028 Ack arriving when outstanding=0 is ignored.

Reset
REQ-029 Reset overrides redirect; sets fetch_pc=resp_pc=RESET_PC, count=0, outstanding=0, state=ABORT, fetch halt flag cleared.
REQ-030 During and one cycle after reset: o_valid=0, o_wb_cycle=0, o_wb_stb=0, o_instruction=0, o_pc=0, o_misaligned=0; first request in the second cycle after reset deasserts.

Configuration
REQ-031 Macro FETCH_MISALIGN_TRAP_EN; with it defined, redirect to pc with pc[1:0]!=0 issues no bus request, pushes one entry {pc, 32'h0, 1} after ABORT and halts requests until the next redirect.
REQ-032 Without FETCH_MISALIGN_TRAP_EN, pc[1:0] ignored for addressing and o_misaligned tied 0.

Structure
REQ-033 Package fetch_pkg holds state enum (RUN, ABORT), WB_SEL_ALL=4'b1111, and the buffer entry struct {pc, instr, misaligned}.
REQ-034 Buffer is one sub-module, fetch_fifo (parametrised DEPTH, synchronous flush, registered read data).

Verification
REQ-035 Zero-wait slave (ack cycle after stb, no stall), i_stall=0, reset release: o_pc sequence 0x0,0x4,0x8 on consecutive cycles once stream starts.
REQ-036 DEPTH=4, i_stall held 1: exactly 4 requests accepted, o_wb_stb drops, count=4; release i_stall: pops 4 entries in order, requests resume.
REQ-037 Slave stall=1 for 3 cycles then ack: fetch_pc does not advance during stall, single entry PC 0x0 appears one cycle after ack.
REQ-038 Redirect to 0x100 with 2 outstanding: next cycle o_wb_cycle=0, o_valid=0; late acks dropped; next entry has o_pc=0x100.
REQ-039 Redirect coincident with reset: after reset first fetch address is RESET_PC, not the redirect PC.
REQ-040 With FETCH_MISALIGN_TRAP_EN, redirect to 0x102: no o_wb_stb, one entry o_pc=0x102, o_misaligned=1; redirect to 0x200 resumes normal fetch.
